// File: rtl/gcd_sequencer.sv
// gcd_sequencer: runs one GCD-core operation per start pulse. It captures the operands, hands
// them to the core over a valid/ready handshake, waits for the result under a cycle-count
// timeout, optionally pads completion to a fixed length, and reports result, count and error.
module gcd_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [11:0] CT_CYCLES  = 12'd256,
  parameter logic [11:0] MAX_CYCLES = 12'd4095
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             START_PULSE,
  input  logic [2:0]       OPCODE,
  input  logic             CONSTANT_TIME,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             CORE_VALID,
  input  logic             CORE_READY,
  output logic [WIDTH-1:0] CORE_A,
  output logic [WIDTH-1:0] CORE_B,
  output logic [2:0]       CORE_OP,
  input  logic             CORE_RES_VALID,
  input  logic [WIDTH-1:0] CORE_RESULT,
  output logic             CORE_ABORT,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE_PULSE,
  output logic [11:0]      CYCLE_COUNT,
  output logic [1:0]       ERR
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StPad, StDone} state_e;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             ct_q, ct_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [12:0]      cnt_inc;
  logic [11:0]      cnt_step;
  logic             at_limit;

  // 13-bit increment so a count already at 4095 cannot wrap in the compares
  assign cnt_inc  = {1'b0, cnt_q} + 13'd1;
  assign at_limit = (cnt_inc >= {1'b0, MAX_CYCLES});
  // Saturate: a handshake on the very last ISSUE cycle must not push the count past the bound
  assign cnt_step = (cnt_inc > {1'b0, MAX_CYCLES}) ? MAX_CYCLES : cnt_inc[11:0];

  // Next-state, capture and per-cycle core strobes
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    ct_d       = ct_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    result_d   = result_q;
    CORE_VALID = 1'b0;
    CORE_ABORT = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START_PULSE) begin
          a_d   = OP_A;
          b_d   = OP_B;
          op_d  = OPCODE;
          ct_d  = CONSTANT_TIME;
          cnt_d = '0;
          if (OPCODE[2]) begin
            state_d = StDone;
            err_d   = ErrIllegal;
          end else begin
            state_d = StIssue;
            err_d   = ErrOk;
          end
        end
      end
      StIssue: begin
        CORE_VALID = 1'b1;
        cnt_d      = cnt_step;
        if (CORE_READY) begin
          state_d = StWait;
        end else if (at_limit) begin
          state_d    = StDone;
          err_d      = ErrTimeout;
          CORE_ABORT = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_step;
        // A result arriving on the timeout cycle still counts as a result
        if (CORE_RES_VALID) begin
          result_d = CORE_RESULT;
          if (!ct_q || (cnt_inc == {1'b0, CT_CYCLES})) begin
            state_d = StDone;
            err_d   = ErrOk;
          end else if (cnt_inc < {1'b0, CT_CYCLES}) begin
            state_d = StPad;
          end else begin
            state_d = StDone;
            err_d   = ErrOverrun;
          end
        end else if (at_limit) begin
          state_d    = StDone;
          err_d      = ErrTimeout;
          CORE_ABORT = 1'b1;
        end
      end
      StPad: begin
        cnt_d = cnt_step;
        if (cnt_inc == {1'b0, CT_CYCLES}) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ct_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ct_q     <= ct_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign CORE_A      = a_q;
  assign CORE_B      = b_q;
  assign CORE_OP     = op_q;
  assign RESULT      = result_q;
  assign CYCLE_COUNT = cnt_q;
  assign ERR         = err_q;
  assign BUSY        = (state_q == StIssue) || (state_q == StWait) || (state_q == StPad);
  assign DONE_PULSE  = (state_q == StDone);

endmodule

// File: tb/tb_gcd_sequencer.sv
// tb_gcd_sequencer: drives operations, plays the GCD core, and scores each completion
// against an outcome computed from cycle budgets.
module tb_gcd_sequencer;

  localparam int unsigned   W   = 32;
  localparam logic [11:0]   CT  = 12'd16;
  localparam logic [11:0]   MAX = 12'd40;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          START_PULSE;
  logic [2:0]    OPCODE;
  logic          CONSTANT_TIME;
  logic [W-1:0]  OP_A, OP_B;
  logic          CORE_VALID, CORE_READY;
  logic [W-1:0]  CORE_A, CORE_B;
  logic [2:0]    CORE_OP;
  logic          CORE_RES_VALID;
  logic [W-1:0]  CORE_RESULT;
  logic          CORE_ABORT;
  logic [W-1:0]  RESULT;
  logic          BUSY, DONE_PULSE;
  logic [11:0]   CYCLE_COUNT;
  logic [1:0]    ERR;

  gcd_sequencer #(.WIDTH(W), .CT_CYCLES(CT), .MAX_CYCLES(MAX)) dut (
    .CLK(CLK), .RESETn(RESETn), .START_PULSE(START_PULSE), .OPCODE(OPCODE),
    .CONSTANT_TIME(CONSTANT_TIME), .OP_A(OP_A), .OP_B(OP_B), .CORE_VALID(CORE_VALID),
    .CORE_READY(CORE_READY), .CORE_A(CORE_A), .CORE_B(CORE_B), .CORE_OP(CORE_OP),
    .CORE_RES_VALID(CORE_RES_VALID), .CORE_RESULT(CORE_RESULT), .CORE_ABORT(CORE_ABORT),
    .RESULT(RESULT), .BUSY(BUSY), .DONE_PULSE(DONE_PULSE), .CYCLE_COUNT(CYCLE_COUNT),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    int          cnt;
    int          err;
    int          aborts;
    int          valids;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  // core stub controls
  int          core_dr = 0;
  int          core_w = 1;
  logic [31:0] core_val = '0;
  bit          core_stray = 0;
  int          stub_k = 0;
  int          stub_j = 0;

  // monitor accumulators
  int          mon_ab = 0;
  int          mon_vc = 0;
  int          mon_bc = 0;
  int          mon_badop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Outcome from cycle budgets: i ISSUE cycles (ready after dr), result w cycles later
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 input bit ct, input int dr, input int w, input int s);
    exp_t e;
    int   i, n;
    e.a = a; e.b = b; e.op = op;
    e.res = last_res; e.aborts = 0; e.valids = 0;
    if (op > 3) begin
      e.cnt = 0; e.err = 1;
    end else begin
      i = dr + 1;
      n = i + w;
      if (i > int'(MAX)) begin
        e.cnt = int'(MAX); e.err = 2; e.aborts = 1; e.valids = int'(MAX);
      end else if (n > int'(MAX)) begin
        e.cnt = int'(MAX); e.err = 2; e.aborts = 1; e.valids = i;
      end else begin
        e.valids = i;
        e.res = gcd(a, b);
        last_res = e.res;
        if (!ct) begin
          e.cnt = n; e.err = 0;
        end else if (n <= int'(CT)) begin
          e.cnt = int'(CT); e.err = 0;
        end else begin
          e.cnt = n; e.err = 3;
        end
      end
    end
    e.done_cyc = s + e.cnt + 1;
    return e;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Core stub: ready after core_dr ISSUE cycles, result on the core_w-th cycle after handshake
  initial forever begin
    @(posedge CLK);
    #1;
    if (!BUSY) begin
      stub_k = 0; stub_j = 0;
      CORE_READY = 1'b0;
      CORE_RES_VALID = core_stray;
      CORE_RESULT = core_stray ? $urandom : '0;
    end else if (CORE_VALID) begin
      stub_k++;
      CORE_READY = (stub_k > core_dr);
      CORE_RES_VALID = 1'b0;
    end else begin
      stub_j++;
      CORE_READY = 1'b0;
      CORE_RES_VALID = (stub_j == core_w);
      CORE_RESULT = (stub_j == core_w) ? core_val : $urandom;
    end
  end

  // Monitor: accumulates per-operation activity, scores it on each DONE_PULSE
  initial forever begin
    @(negedge CLK);
    if (!RESETn) begin
      mon_ab = 0; mon_vc = 0; mon_bc = 0; mon_badop = 0;
    end else begin
      if (CORE_ABORT) mon_ab++;
      if (BUSY) mon_bc++;
      if (CORE_VALID) begin
        mon_vc++;
        if (q.size() > 0 &&
            (CORE_A !== q[0].a || CORE_B !== q[0].b || CORE_OP !== q[0].op)) mon_badop++;
      end
      if (DONE_PULSE) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("result", 64'(RESULT), 64'(mon_e.res));
          check("cycle_count", 64'(CYCLE_COUNT), 64'(mon_e.cnt));
          check("err", 64'(ERR), 64'(mon_e.err));
          check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          check("abort_pulses", 64'(mon_ab), 64'(mon_e.aborts));
          check("valid_cycles", 64'(mon_vc), 64'(mon_e.valids));
          check("busy_cycles", 64'(mon_bc), 64'(mon_e.cnt));
          check("core_operands", 64'(mon_badop), 64'd0);
        end
        mon_ab = 0; mon_vc = 0; mon_bc = 0; mon_badop = 0;
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input bit ct, input int dr, input int w, input bit stray,
                        input int extra_at);
    exp_t e;
    int   s;
    core_dr = dr; core_w = w; core_val = gcd(a, b); core_stray = stray;
    @(posedge CLK);
    #1;
    START_PULSE = 1'b1; OP_A = a; OP_B = b; OPCODE = op; CONSTANT_TIME = ct;
    s = cyc;
    e = model(a, b, op, ct, dr, w, s);
    q.push_back(e);
    @(posedge CLK);
    #1;
    START_PULSE = 1'b0; OP_A = $urandom; OP_B = $urandom; OPCODE = 3'($urandom);
    CONSTANT_TIME = 1'($urandom);
    if (extra_at > 0) begin
      repeat (extra_at - 1) @(posedge CLK);
      #1;
      START_PULSE = 1'b1; OPCODE = 3'd5; OP_A = $urandom;
      @(posedge CLK);
      #1;
      START_PULSE = 1'b0;
    end
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge CLK);
    check("op_completed", 64'(q.size()), 64'd0);
    q.delete();
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    RESETn = 1'b0; START_PULSE = 1'b0; OPCODE = '0; CONSTANT_TIME = 1'b0;
    OP_A = '0; OP_B = '0; CORE_READY = 1'b0; CORE_RES_VALID = 1'b0; CORE_RESULT = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", 64'(RESULT), 64'd0);
    check("rst_count", 64'(CYCLE_COUNT), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE_PULSE), 64'd0);
    check("rst_valid", 64'(CORE_VALID), 64'd0);
    check("rst_abort", 64'(CORE_ABORT), 64'd0);
    check("rst_core_ab", 64'({CORE_A, CORE_B, CORE_OP} != 0), 64'd0);
    RESETn = 1'b1;

    // directed: a, b, op, ct, ready delay, result delay, stray result, extra start
    run_op(48, 18, 0, 0, 0, 5, 0, 0);      // plain: count 6
    run_op(48, 18, 0, 1, 0, 5, 0, 0);      // padded to 16
    run_op(7, 9, 5, 0, 0, 5, 1, 0);        // illegal opcode, stray result in idle
    run_op(100, 75, 1, 0, 100, 5, 0, 0);   // ready never comes: timeout in ISSUE
    run_op(48, 18, 0, 1, 0, 20, 0, 0);     // constant-time overrun
    run_op(1071, 462, 2, 1, 3, 12, 0, 0);  // lands exactly on the pad length
    run_op(36, 24, 3, 0, 9, 30, 0, 0);     // result on the timeout cycle wins
    run_op(36, 24, 3, 0, 9, 31, 0, 0);     // timeout in WAIT
    run_op(48, 18, 0, 0, 0, 8, 0, 4);      // second start during WAIT is ignored
    run_op(5, 10, 7, 1, 0, 5, 0, 0);       // illegal opcode 7

    // reset in the middle of WAIT: no completion, everything cleared
    core_dr = 0; core_w = 30; core_stray = 0; core_val = 99;
    @(posedge CLK);
    #1;
    START_PULSE = 1'b1; OP_A = 99; OP_B = 33; OPCODE = 0; CONSTANT_TIME = 0;
    @(posedge CLK);
    #1;
    START_PULSE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("busy_before_reset", 64'(BUSY), 64'd1);
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_valid", 64'(CORE_VALID), 64'd0);
    check("mid_rst_done", 64'(DONE_PULSE), 64'd0);
    check("mid_rst_count", 64'(CYCLE_COUNT), 64'd0);
    check("mid_rst_result", 64'(RESULT), 64'd0);
    check("mid_rst_err", 64'(ERR), 64'd0);
    check("mid_rst_core_ab", 64'({CORE_A, CORE_B, CORE_OP} != 0), 64'd0);
    RESETn = 1'b1;
    last_res = '0;
    repeat (40) @(posedge CLK);
    run_op(48, 18, 0, 0, 2, 5, 0, 0);

    for (int n = 0; n < 30; n++) begin
      g = $urandom_range(1, 500);
      run_op(g * $urandom_range(1, 1000), g * $urandom_range(1, 1000),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 8), $urandom_range(1, 40), 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
